rst_seq: RTL and testbench

Multi-stage reset sequencer.
- Sits directly behind clk_rst and takes its conditioned clk/rst.
- Drives one reset line per subsystem (e.g. memory controller, SDRAM PHY, CPU, bus peripherals).
- Releases the lines in a fixed order, with a programmable hold-off delay per stage.
- Optionally waits for a per-stage ready acknowledge, with a timeout.
- On timeout it retries the whole sequence a bounded number of times, then reports failure.

---
 rtl/rst_seq_pkg.sv | 27 ++
 rtl/rst_seq_tmr.sv | 38 +++
 rtl/rst_seq.sv | 176 +++++++++++++++++
 tb/tb_rst_seq.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the multi-stage reset sequencer.
package rst_seq_pkg;

  // Widest packed delay table the helper accepts (8 stages x 32 bits).
  localparam int unsigned PACK_W = 256;
  // Width of the stage index and retry counter outputs.
  localparam int unsigned STG_W  = 3;

  typedef enum logic [1:0] {
    ST_DELAY    = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_DONE     = 2'd2,
    ST_FAIL     = 2'd3
  } state_e;

  // Pull field idx (dly_w bits wide) out of a packed per-stage delay table.
  function automatic logic [31:0] dly_field(input logic [PACK_W-1:0] table_v,
                                            input int unsigned       idx,
                                            input int unsigned       dly_w);
    logic [PACK_W-1:0] shifted;
    logic [PACK_W-1:0] mask;
    shifted = table_v >> (idx * dly_w);
    mask    = (PACK_W'(1) << dly_w) - PACK_W'(1);
    return 32'(shifted & mask);
  endfunction

endpackage

// File: rtl/rst_seq_tmr.sv
// Up-counter shared by the hold-off delay and ack timeout phases.
// Clearing reloads zero; match_c_o flags that the count equals term_i.
module rst_seq_tmr #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] term_i,
  output logic         match_c_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_c_o = (cnt_q == term_i);

endmodule

// File: rtl/rst_seq.sv
// Multi-stage reset sequencer: releases per-subsystem resets in ascending
// order after a per-stage hold-off, optionally waiting for a ready ack with
// timeout, retrying the whole sequence a bounded number of times.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int unsigned            NSTG      = 4,
  parameter int unsigned            DLY_W     = 8,
  parameter logic [NSTG*DLY_W-1:0]  STG_DELAY = 32'h04020503,
  parameter logic [NSTG-1:0]        ACK_MASK  = 4'b0010,
  parameter int unsigned            TMO_W     = 16,
  parameter int unsigned            TMO       = 20,
  parameter int unsigned            MAX_RETRY = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sw_rst_req,
  input  logic [NSTG-1:0] rdy_in,
  output logic [NSTG-1:0] rst_out,
  output logic [2:0]      stage,
  output logic [2:0]      retry_cnt,
  output logic            all_done,
  output logic            fail
);

  localparam int unsigned CNT_W = (DLY_W > TMO_W) ? DLY_W : TMO_W;

  state_e            state_q, state_d;
  logic [NSTG-1:0]   rst_out_q, rst_out_d;
  logic [STG_W-1:0]  stage_q, stage_d;
  logic [STG_W-1:0]  retry_q, retry_d;
  logic              done_q, done_d;
  logic              fail_q, fail_d;

  logic              tmr_clr;
  logic              tmr_inc;
  logic              tmr_match;
  logic [CNT_W-1:0]  tmr_term;
  logic [CNT_W-1:0]  dly_term;
  logic              cur_ack;
  logic              cur_rdy;
  logic              stg_cmpl;
  logic              ack_tmo;

  rst_seq_tmr #(
    .W (CNT_W)
  ) u_tmr (
    .clk_i     (clk),
    .rst_i     (rst),
    .clr_i     (tmr_clr),
    .inc_i     (tmr_inc),
    .term_i    (tmr_term),
    .match_c_o (tmr_match)
  );

  // Per-stage view of the current stage: ack enable, ready input, hold-off.
  always_comb begin
    cur_ack  = 1'b0;
    cur_rdy  = 1'b0;
    dly_term = '0;
    for (int unsigned i = 0; i < NSTG; i++) begin
      if (stage_q == STG_W'(i)) begin
        cur_ack  = ACK_MASK[i];
        cur_rdy  = rdy_in[i];
        dly_term = CNT_W'(dly_field(PACK_W'(STG_DELAY), i, DLY_W));
      end
    end
    // Timeout fires when the R+TMO sample is still low, i.e. count TMO-1.
    tmr_term = (state_q == ST_WAIT_ACK) ? CNT_W'(TMO - 1) : dly_term;
  end

  // Next-state and output logic.
  always_comb begin
    state_d   = state_q;
    rst_out_d = rst_out_q;
    stage_d   = stage_q;
    retry_d   = retry_q;
    done_d    = done_q;
    fail_d    = fail_q;
    tmr_clr   = 1'b0;
    tmr_inc   = 1'b0;
    stg_cmpl  = 1'b0;
    ack_tmo   = 1'b0;

    if (sw_rst_req) begin
      state_d   = ST_DELAY;
      rst_out_d = '1;
      stage_d   = '0;
      retry_d   = '0;
      done_d    = 1'b0;
      fail_d    = 1'b0;
      tmr_clr   = 1'b1;
    end else begin
      unique case (state_q)
        ST_DELAY: begin
          if (tmr_match) begin
            for (int unsigned i = 0; i < NSTG; i++) begin
              if (stage_q == STG_W'(i)) rst_out_d[i] = 1'b0;
            end
            if (cur_ack) begin
              state_d = ST_WAIT_ACK;
              tmr_clr = 1'b1;
            end else begin
              stg_cmpl = 1'b1;
            end
          end else begin
            tmr_inc = 1'b1;
          end
        end
        ST_WAIT_ACK: begin
          // Ack sampled at the terminal edge still counts as in time.
          if (cur_rdy) begin
            stg_cmpl = 1'b1;
          end else if (tmr_match) begin
            ack_tmo = 1'b1;
          end else begin
            tmr_inc = 1'b1;
          end
        end
        default: begin
          // DONE and FAIL hold until a reset request.
        end
      endcase

      if (stg_cmpl) begin
        if (stage_q == STG_W'(NSTG - 1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          stage_d = stage_q + STG_W'(1);
          state_d = ST_DELAY;
          tmr_clr = 1'b1;
        end
      end

      if (ack_tmo) begin
        rst_out_d = '1;
        if (retry_q < STG_W'(MAX_RETRY)) begin
          retry_d = retry_q + STG_W'(1);
          stage_d = '0;
          state_d = ST_DELAY;
          tmr_clr = 1'b1;
        end else begin
          state_d = ST_FAIL;
          fail_d  = 1'b1;
        end
      end
    end
  end

  // State and output registers; rst overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_DELAY;
      rst_out_q <= '1;
      stage_q   <= '0;
      retry_q   <= '0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rst_out_q <= rst_out_d;
      stage_q   <= stage_d;
      retry_q   <= retry_d;
      done_q    <= done_d;
      fail_q    <= fail_d;
    end
  end

  assign rst_out   = rst_out_q;
  assign stage     = stage_q;
  assign retry_cnt = retry_q;
  assign all_done  = done_q;
  assign fail      = fail_q;

endmodule

// File: tb/tb_rst_seq.sv
// Scoreboard bench for rst_seq: a timeline model predicts every cycle's
// outputs; a monitor compares them and checks the key release edges.
module tb_rst_seq;

  localparam int unsigned NSTG      = 4;
  localparam int          TMO       = 20;
  localparam int          MAX_RETRY = 1;
  localparam logic [3:0]  ACKM      = 4'b0010;

  logic       clk = 1'b0;
  logic       rst;
  logic       sw_rst_req;
  logic [3:0] rdy_in;
  logic [3:0] rst_out, v_rst_out;
  logic [2:0] stage, retry_cnt, v_stage, v_retry_cnt;
  logic       all_done, fail, v_all_done, v_fail;

  always #5 clk = ~clk;

  rst_seq u_dut (
    .clk        (clk),
    .rst        (rst),
    .sw_rst_req (sw_rst_req),
    .rdy_in     (rdy_in),
    .rst_out    (rst_out),
    .stage      (stage),
    .retry_cnt  (retry_cnt),
    .all_done   (all_done),
    .fail       (fail)
  );

  rst_seq #(
    .STG_DELAY (32'h0),
    .ACK_MASK  (4'b0000)
  ) u_var (
    .clk        (clk),
    .rst        (rst),
    .sw_rst_req (sw_rst_req),
    .rdy_in     (rdy_in),
    .rst_out    (v_rst_out),
    .stage      (v_stage),
    .retry_cnt  (v_retry_cnt),
    .all_done   (v_all_done),
    .fail       (v_fail)
  );

  typedef struct packed {
    logic [3:0] rst_out;
    logic [2:0] stage;
    logic [2:0] retry;
    logic       done;
    logic       fail;
    int         edge_n;
  } exp_t;

  typedef struct packed {
    int sel;
    int exp_v;
  } dchk_t;

  exp_t  exp_q[$];
  dchk_t d_q[$];

  int cyc       = 0;
  int edge0     = 0;
  bit stim_done = 1'b0;
  int n_chk     = 0;
  int n_fail    = 0;

  // ---------------- reference model (edge timeline arithmetic) -------------
  int         dly [4] = '{3, 5, 2, 4};
  logic [3:0] m_rst;
  int         m_stage, m_retry, m_anchor, m_rel, m_mode;  // mode 0 run,1 done,2 failed
  bit         m_done, m_fail;

  task automatic m_restart(input int n);
    m_rst    = 4'hF;
    m_stage  = 0;
    m_anchor = n;
    m_rel    = -1;
    m_mode   = 0;
    m_done   = 1'b0;
  endtask

  task automatic m_complete(input int n);
    if (m_stage == 3) begin
      m_mode = 1;
      m_done = 1'b1;
    end else begin
      m_stage  = m_stage + 1;
      m_anchor = n;
      m_rel    = -1;
    end
  endtask

  task automatic model_step(input int n, input bit r, input bit sw, input logic [3:0] rdy);
    if (r || sw) begin
      m_restart(n);
      m_retry = 0;
      m_fail  = 1'b0;
    end else if (m_mode == 0) begin
      if (m_rel < 0) begin
        if (n == m_anchor + dly[m_stage] + 1) begin
          m_rst = m_rst & ~(4'b0001 << m_stage);
          if (((ACKM >> m_stage) & 4'b0001) != 4'b0000) m_rel = n;
          else m_complete(n);
        end
      end else if (((rdy >> m_stage) & 4'b0001) != 4'b0000) begin
        m_complete(n);
      end else if (n == m_rel + TMO) begin
        if (m_retry < MAX_RETRY) begin
          m_retry = m_retry + 1;
          m_restart(n);
        end else begin
          m_rst  = 4'hF;
          m_mode = 2;
          m_fail = 1'b1;
        end
      end
    end
  endtask

  // ---------------- stimulus ----------------------------------------------
  task automatic do_cycle(input bit r, input bit sw, input logic [3:0] rdy);
    exp_t e;
    @(negedge clk);
    rst        = r;
    sw_rst_req = sw;
    rdy_in     = rdy;
    @(posedge clk);
    cyc = cyc + 1;
    if (r) edge0 = cyc;
    model_step(cyc, r, sw, rdy);
    e.rst_out = m_rst;
    e.stage   = 3'(m_stage);
    e.retry   = 3'(m_retry);
    e.done    = m_done;
    e.fail    = m_fail;
    e.edge_n  = cyc;
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input logic [3:0] rdy);
    do_cycle(1'b1, 1'b0, rdy);
    do_cycle(1'b1, 1'b0, rdy);
  endtask

  task automatic dir(input int sel, input int v);
    dchk_t d;
    d.sel   = sel;
    d.exp_v = v;
    d_q.push_back(d);
  endtask

  function automatic string sel_name(input int sel);
    case (sel)
      0: return "fall_rst_out0";
      1: return "fall_rst_out1";
      2: return "fall_rst_out2";
      3: return "fall_rst_out3";
      4: return "all_done_rise";
      5: return "fail_rise";
      6: return "var_fall_rst_out0";
      7: return "var_fall_rst_out1";
      8: return "var_fall_rst_out2";
      9: return "var_fall_rst_out3";
      default: return "var_all_done_rise";
    endcase
  endfunction

  initial begin
    int p;
    int len;
    logic [3:0] rdy;
    rst        = 1'b1;
    sw_rst_req = 1'b0;
    rdy_in     = 4'h0;

    // Nominal sequence; ack on stage 1 sampled at e17. Variant releases e1..e4.
    do_reset(4'h0);
    while (cyc - edge0 < 30) do_cycle(1'b0, 1'b0, (cyc + 1 - edge0 >= 17) ? 4'b0010 : 4'b0000);
    dir(0, 4); dir(1, 10); dir(2, 20); dir(3, 25); dir(4, 25);
    dir(6, 1); dir(7, 2); dir(8, 3); dir(9, 4); dir(10, 4);

    // Software reset pulse at e40 after completion.
    while (cyc - edge0 < 39) do_cycle(1'b0, 1'b0, 4'b0010);
    do_cycle(1'b0, 1'b1, 4'b0010);
    while (cyc - edge0 < 50) do_cycle(1'b0, 1'b0, 4'b0010);
    dir(0, 44);

    // No ack ever: one retry, then sticky fail held for 100 cycles.
    do_reset(4'h0);
    while (cyc - edge0 < 160) do_cycle(1'b0, 1'b0, 4'h0);
    dir(0, 34); dir(1, 40); dir(5, 60);

    // Ready high from reset: high at the release edge is ignored.
    do_reset(4'hF);
    while (cyc - edge0 < 30) do_cycle(1'b0, 1'b0, 4'hF);
    dir(1, 10); dir(2, 14); dir(3, 19); dir(4, 19);

    // rst together with sw_rst_req at e12 during WAIT_ACK.
    do_reset(4'h0);
    while (cyc - edge0 < 11) do_cycle(1'b0, 1'b0, 4'h0);
    do_cycle(1'b1, 1'b1, 4'h0);
    while (cyc - edge0 < 30) do_cycle(1'b0, 1'b0, 4'b0010);
    dir(0, 4); dir(1, 10); dir(2, 14);

    // Randomized segments with varying ready density and rare resets.
    for (int seg = 0; seg < 20; seg++) begin
      p   = (seg % 4 == 0) ? 0 : ((seg % 4 == 1) ? 4 : ((seg % 4 == 2) ? 30 : 90));
      len = 100 + int'($urandom_range(0, 100));
      if (seg % 3 == 0) do_reset(4'h0);
      for (int k = 0; k < len; k++) begin
        for (int b = 0; b < 4; b++) rdy[b] = ($urandom_range(0, 99) < p);
        do_cycle($urandom_range(0, 499) == 0, $urandom_range(0, 249) == 0, rdy);
      end
    end
    stim_done = 1'b1;
  end

  // ---------------- monitor / scoreboard ----------------------------------
  initial begin
    exp_t       e;
    dchk_t      d;
    int         obs [11];
    logic [3:0] prev_ro, prev_vro;
    logic       prev_done, prev_fail, prev_vdone;
    int         idle;
    int         ticks;
    int         act;
    idle  = 0;
    ticks = 0;
    for (int i = 0; i < 11; i++) obs[i] = -1;
    prev_ro    = 4'hx;
    prev_vro   = 4'hx;
    prev_done  = 1'bx;
    prev_fail  = 1'bx;
    prev_vdone = 1'bx;
    forever begin
      @(negedge clk);
      ticks = ticks + 1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_chk = n_chk + 1;
        if ({rst_out, stage, retry_cnt, all_done, fail} !==
            {e.rst_out, e.stage, e.retry, e.done, e.fail}) begin
          n_fail = n_fail + 1;
          $display("FAIL outputs e%0d: got rst_out=%b stage=%0d retry=%0d done=%b fail=%b, want rst_out=%b stage=%0d retry=%0d done=%b fail=%b",
                   e.edge_n - edge0, rst_out, stage, retry_cnt, all_done, fail,
                   e.rst_out, e.stage, e.retry, e.done, e.fail);
        end
        n_chk = n_chk + 1;
        if (v_fail !== 1'b0 || v_retry_cnt !== 3'd0 || !(v_stage <= 3'd3)) begin
          n_fail = n_fail + 1;
          $display("FAIL variant_flags e%0d: got fail=%b retry=%0d stage=%0d, want fail=0 retry=0 stage<=3",
                   e.edge_n - edge0, v_fail, v_retry_cnt, v_stage);
        end
        for (int i = 0; i < 4; i++) begin
          if (prev_ro[i] === 1'b1 && rst_out[i] === 1'b0) obs[i] = e.edge_n;
          if (prev_vro[i] === 1'b1 && v_rst_out[i] === 1'b0) obs[6 + i] = e.edge_n;
        end
        if (prev_done !== 1'b1 && all_done === 1'b1) obs[4] = e.edge_n;
        if (prev_fail !== 1'b1 && fail === 1'b1) obs[5] = e.edge_n;
        if (prev_vdone !== 1'b1 && v_all_done === 1'b1) obs[10] = e.edge_n;
        prev_ro    = rst_out;
        prev_vro   = v_rst_out;
        prev_done  = all_done;
        prev_fail  = fail;
        prev_vdone = v_all_done;
      end
      while (d_q.size() > 0) begin
        d   = d_q.pop_front();
        act = obs[d.sel] - edge0;
        n_chk = n_chk + 1;
        if (act != d.exp_v) begin
          n_fail = n_fail + 1;
          $display("FAIL %s: got edge %0d, want edge %0d", sel_name(d.sel), act, d.exp_v);
        end
      end
      if (stim_done) begin
        idle = idle + 1;
        if (exp_q.size() == 0 && d_q.size() == 0) break;
        if (idle > 10) begin
          n_chk  = n_chk + 1;
          n_fail = n_fail + 1;
          $display("FAIL drain: %0d entries left, want 0", exp_q.size() + d_q.size());
          break;
        end
      end
      if (ticks > 50000) begin
        n_chk  = n_chk + 1;
        n_fail = n_fail + 1;
        $display("FAIL run_time: got %0d cycles, want at most 50000", ticks);
        break;
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
